// File: rtl/tank_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tank_motion_ctrl
// Brief    : Per-frame movement of two tanks with edge clamping and collision.
// Revision : 1.0
// ============================================================================

module tank_motion_ctrl #(
  parameter int VIDEO_WIDTH  = 640,
  parameter int VIDEO_HEIGHT = 480,
  parameter int SPRITE_SIZE  = 64,
  parameter int STEP         = 3,
  parameter int P1_X0        = 32,
  parameter int P1_Y0        = 208,
  parameter int P2_X0        = 544,
  parameter int P2_Y0        = 208
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        screenEnd,
  input  logic        p1_up,
  input  logic        p1_down,
  input  logic        p1_left,
  input  logic        p1_right,
  input  logic        p2_up,
  input  logic        p2_down,
  input  logic        p2_left,
  input  logic        p2_right,
  output logic [9:0]  p1X,
  output logic [10:0] p1Y,
  output logic [9:0]  p2X,
  output logic [10:0] p2Y,
  output logic        frame_done
);

  localparam logic [11:0] C_STEP = 12'(STEP);
  localparam logic [11:0] C_SIZE = 12'(SPRITE_SIZE);
  localparam logic [11:0] C_VW   = 12'(VIDEO_WIDTH);
  localparam logic [11:0] C_VH   = 12'(VIDEO_HEIGHT);

  typedef enum logic [1:0] {IDLE, MOVE1, MOVE2, DONE} state_t;

  state_t      state_q;
  logic        sync1_q, sync2_q, sync3_q;
  logic [1:0]  vld_q;
  logic        armed_q;
  logic [3:0]  dir1_q, dir2_q;
  logic [9:0]  p1x_q, p2x_q, p1x_d, p2x_d;
  logic [10:0] p1y_q, p2y_q, p1y_d, p2y_d;
  logic        frame_done_q;
  logic        frame_tick;

  function automatic logic [11:0] axis_cand(input logic [11:0] pos, input logic dec,
                                            input logic inc, input logic [11:0] lim);
    logic [11:0] r;
    r = pos;
    if (inc && !dec)
      r = (pos + C_SIZE + C_STEP <= lim) ? pos + C_STEP : lim - C_SIZE;
    else if (dec && !inc)
      r = (pos >= C_STEP) ? pos - C_STEP : 12'd0;
    return r;
  endfunction

  function automatic logic overlap(input logic [11:0] ax, input logic [11:0] ay,
                                   input logic [11:0] bx, input logic [11:0] by);
    logic [11:0] dx, dy;
    dx = (ax >= bx) ? ax - bx : bx - ax;
    dy = (ay >= by) ? ay - by : by - ay;
    return (dx < C_SIZE) && (dy < C_SIZE);
  endfunction

  // dir = {up, down, left, right}; result packed as {x, y}
  function automatic logic [23:0] resolve(input logic [11:0] x, input logic [11:0] y,
                                          input logic [3:0] dir,
                                          input logic [11:0] ox, input logic [11:0] oy);
    logic [11:0] cx, cy;
    logic [23:0] r;
    cx = axis_cand(x, dir[1], dir[0], C_VW);
    cy = axis_cand(y, dir[3], dir[2], C_VH);
    if (!overlap(cx, cy, ox, oy))     r = {cx, cy};
    else if (!overlap(cx, y, ox, oy)) r = {cx, y};
    else if (!overlap(x, cy, ox, oy)) r = {x, cy};
    else                              r = {x, y};
    return r;
  endfunction

  assign frame_tick = sync2_q & ~sync3_q & armed_q;

  // p2 is resolved in MOVE2, when p1 registers already hold this frame's result
  always_comb begin
    logic [23:0] r1, r2;
    r1 = resolve(12'(p1x_q), 12'(p1y_q), dir1_q, 12'(p2x_q), 12'(p2y_q));
    r2 = resolve(12'(p2x_q), 12'(p2y_q), dir2_q, 12'(p1x_q), 12'(p1y_q));
    p1x_d = 10'(r1[23:12]);
    p1y_d = 11'(r1[11:0]);
    p2x_d = 10'(r2[23:12]);
    p2y_d = 11'(r2[11:0]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      sync3_q      <= 1'b0;
      vld_q        <= 2'b00;
      armed_q      <= 1'b0;
      dir1_q       <= 4'b0;
      dir2_q       <= 4'b0;
      p1x_q        <= 10'(P1_X0);
      p1y_q        <= 11'(P1_Y0);
      p2x_q        <= 10'(P2_X0);
      p2y_q        <= 11'(P2_Y0);
      frame_done_q <= 1'b0;
    end else begin
      sync1_q      <= screenEnd;
      sync2_q      <= sync1_q;
      sync3_q      <= sync2_q;
      // a tick needs the synchronized level to be seen low after reset first
      vld_q        <= {vld_q[0], 1'b1};
      armed_q      <= armed_q | (vld_q[1] & ~sync2_q);
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (frame_tick) begin
            dir1_q  <= {p1_up, p1_down, p1_left, p1_right};
            dir2_q  <= {p2_up, p2_down, p2_left, p2_right};
            state_q <= MOVE1;
          end
        end
        MOVE1: begin
          p1x_q   <= p1x_d;
          p1y_q   <= p1y_d;
          state_q <= MOVE2;
        end
        MOVE2: begin
          p2x_q        <= p2x_d;
          p2y_q        <= p2y_d;
          frame_done_q <= 1'b1;
          state_q      <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign p1X        = p1x_q;
  assign p1Y        = p1y_q;
  assign p2X        = p2x_q;
  assign p2Y        = p2y_q;
  assign frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_tank_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tank_motion_ctrl
// Brief    : Self-checking bench for tank_motion_ctrl against a frame-level model.
// Revision : 1.0
// ============================================================================

module tb_tank_motion_ctrl;

  localparam int W  = 640;
  localparam int H  = 480;
  localparam int S  = 64;
  localparam int ST = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        screenEnd;
  logic        p1_up, p1_down, p1_left, p1_right;
  logic        p2_up, p2_down, p2_left, p2_right;
  logic [9:0]  p1X, p2X;
  logic [10:0] p1Y, p2Y;
  logic        frame_done;

  int tests = 0;
  int fails = 0;
  int mx1, my1, mx2, my2;

  tank_motion_ctrl dut (
    .clk(clk), .reset(reset), .screenEnd(screenEnd),
    .p1_up(p1_up), .p1_down(p1_down), .p1_left(p1_left), .p1_right(p1_right),
    .p2_up(p2_up), .p2_down(p2_down), .p2_left(p2_left), .p2_right(p2_right),
    .p1X(p1X), .p1Y(p1Y), .p2X(p2X), .p2Y(p2Y), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (frame level) ----------------
  function automatic int axis_move(int p, bit dec, bit inc, int lim);
    if (inc && !dec) return (p + S + ST <= lim) ? p + ST : lim - S;
    if (dec && !inc) return (p >= ST) ? p - ST : 0;
    return p;
  endfunction

  function automatic bit boxes_overlap(int ax, int ay, int bx, int by);
    int dx, dy;
    dx = ax - bx; if (dx < 0) dx = -dx;
    dy = ay - by; if (dy < 0) dy = -dy;
    return (dx < S) && (dy < S);
  endfunction

  task automatic model_player(inout int x, inout int y, input logic [3:0] d,
                              input int ox, input int oy);
    int cx, cy;
    int tx[4];
    int ty[4];
    cx = axis_move(x, d[1], d[0], W);
    cy = axis_move(y, d[3], d[2], H);
    tx[0] = cx; ty[0] = cy;
    tx[1] = cx; ty[1] = y;
    tx[2] = x;  ty[2] = cy;
    tx[3] = x;  ty[3] = y;
    for (int i = 0; i < 4; i++) begin
      if (!boxes_overlap(tx[i], ty[i], ox, oy)) begin
        x = tx[i]; y = ty[i];
        return;
      end
    end
  endtask

  task automatic model_frame(input logic [3:0] d1, input logic [3:0] d2);
    model_player(mx1, my1, d1, mx2, my2);
    model_player(mx2, my2, d2, mx1, my1);
  endtask

  task automatic model_reset();
    mx1 = 32; my1 = 208; mx2 = 544; my2 = 208;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick_clk();
    @(posedge clk); #1;
  endtask

  // d = {up, down, left, right}
  task automatic set_dirs(input logic [3:0] d1, input logic [3:0] d2);
    {p1_up, p1_down, p1_left, p1_right} = d1;
    {p2_up, p2_down, p2_left, p2_right} = d2;
  endtask

  task automatic apply_reset();
    reset = 1'b1; screenEnd = 1'b0; set_dirs(4'b0, 4'b0);
    repeat (2) tick_clk();
    reset = 1'b0;
    repeat (4) tick_clk();
    model_reset();
  endtask

  // One full frame; inputs are scrambled once the sequence is underway to show they were latched.
  task automatic do_frame(input logic [3:0] d1, input logic [3:0] d2, output int lat);
    set_dirs(d1, d2);
    screenEnd = 1'b1;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      tick_clk();
      if (k == 3) set_dirs(4'($urandom), 4'($urandom));
      if (frame_done) begin lat = k; break; end
    end
    screenEnd = 1'b0;
    set_dirs(4'b0, 4'b0);
    repeat (4) tick_clk();
    model_frame(d1, d2);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    tests++;
    if ({p1X, p1Y, p2X, p2Y, frame_done} !== {10'd32, 11'd208, 10'd544, 11'd208, 1'b0}) begin
      fails++;
      $display("FAIL reset_state: got p1=(%0d,%0d) p2=(%0d,%0d) fd=%b, want (32,208) (544,208) 0",
               p1X, p1Y, p2X, p2Y, frame_done);
    end
  endtask

  task automatic test_latency();
    logic [6:1] fd;
    int x_k3, x_k4;
    apply_reset();
    set_dirs(4'b0001, 4'b0000);
    screenEnd = 1'b1;
    fd = '0; x_k3 = -1; x_k4 = -1;
    for (int k = 1; k <= 6; k++) begin
      tick_clk();
      fd[k] = frame_done;
      if (k == 3) x_k3 = int'(p1X);
      if (k == 4) x_k4 = int'(p1X);
    end
    screenEnd = 1'b0; set_dirs(4'b0, 4'b0);
    repeat (4) tick_clk();
    model_frame(4'b0001, 4'b0000);
    tests++;
    if (fd !== 6'b010000) begin
      fails++; $display("FAIL latency_frame_done: got pattern %b, want 010000", fd);
    end
    tests++;
    if (x_k3 != 32 || x_k4 != 35) begin
      fails++; $display("FAIL latency_p1: got x@3=%0d x@4=%0d, want 32 35", x_k3, x_k4);
    end
    tests++;
    if ({p1X, p1Y, p2X, p2Y} !== {10'd35, 11'd208, 10'd544, 11'd208}) begin
      fails++;
      $display("FAIL single_right: got p1=(%0d,%0d) p2=(%0d,%0d), want (35,208) (544,208)",
               p1X, p1Y, p2X, p2Y);
    end
  endtask

  task automatic test_left_edge();
    int lat;
    apply_reset();
    repeat (10) do_frame(4'b0010, 4'b0000, lat);
    tests++;
    if (p1X !== 10'd2) begin fails++; $display("FAIL left_edge_2: got %0d, want 2", p1X); end
    do_frame(4'b0010, 4'b0000, lat);
    tests++;
    if (p1X !== 10'd0) begin fails++; $display("FAIL left_edge_0: got %0d, want 0", p1X); end
    do_frame(4'b0010, 4'b0000, lat);
    tests++;
    if (p1X !== 10'd0 || lat != 5) begin
      fails++; $display("FAIL left_edge_hold: got x=%0d lat=%0d, want 0 5", p1X, lat);
    end
  endtask

  task automatic test_right_edge();
    int lat;
    apply_reset();
    repeat (70) do_frame(4'b0000, 4'b1000, lat);
    tests++;
    if (p2Y !== 11'd0) begin fails++; $display("FAIL top_edge: got p2Y=%0d, want 0", p2Y); end
    repeat (181) do_frame(4'b0001, 4'b0000, lat);
    tests++;
    if (p1X !== 10'd575) begin fails++; $display("FAIL right_575: got %0d, want 575", p1X); end
    for (int i = 0; i < 3; i++) begin
      do_frame(4'b0001, 4'b0000, lat);
      tests++;
      if (p1X !== 10'd576 || mx1 != 576) begin
        fails++; $display("FAIL right_clamp: got %0d model %0d, want 576", p1X, mx1);
      end
    end
  endtask

  task automatic test_opposite();
    int lat;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      do_frame(4'b1111, 4'b0000, lat);
      tests++;
      if ({p1X, p1Y} !== {10'd32, 11'd208}) begin
        fails++; $display("FAIL opposite_dirs: got (%0d,%0d), want (32,208)", p1X, p1Y);
      end
    end
  endtask

  task automatic test_collision();
    int lat;
    apply_reset();
    repeat (149) do_frame(4'b0001, 4'b0000, lat);
    do_frame(4'b0101, 4'b0000, lat);
    tests++;
    if ({p1X, p1Y} !== {10'd479, 11'd211} || mx1 != 479 || my1 != 211) begin
      fails++; $display("FAIL collide_slide: got (%0d,%0d) model (%0d,%0d), want (479,211)",
                        p1X, p1Y, mx1, my1);
    end
    apply_reset();
    repeat (149) do_frame(4'b0001, 4'b0000, lat);
    do_frame(4'b0001, 4'b0000, lat);
    tests++;
    if ({p1X, p1Y} !== {10'd479, 11'd208}) begin
      fails++; $display("FAIL collide_hold: got (%0d,%0d), want (479,208)", p1X, p1Y);
    end
  endtask

  task automatic test_double_pulse();
    int pulses;
    logic [3:0] d1, d2;
    d1 = 4'($urandom); d2 = 4'($urandom);
    set_dirs(d1, d2);
    pulses = 0;
    screenEnd = 1'b1; tick_clk(); if (frame_done) pulses++;
    screenEnd = 1'b0; tick_clk(); if (frame_done) pulses++;
    screenEnd = 1'b1;
    for (int k = 0; k < 20; k++) begin tick_clk(); if (frame_done) pulses++; end
    screenEnd = 1'b0; set_dirs(4'b0, 4'b0);
    repeat (4) tick_clk();
    model_frame(d1, d2);
    tests++;
    if (pulses != 1) begin fails++; $display("FAIL double_pulse_count: got %0d, want 1", pulses); end
    tests++;
    if ({p1X, p1Y, p2X, p2Y} !== {10'(mx1), 11'(my1), 10'(mx2), 11'(my2)}) begin
      fails++; $display("FAIL double_pulse_pos: got (%0d,%0d)(%0d,%0d), want (%0d,%0d)(%0d,%0d)",
                        p1X, p1Y, p2X, p2Y, mx1, my1, mx2, my2);
    end
  endtask

  task automatic test_reset_mid();
    int lat, pulses;
    do_frame(4'b0101, 4'b1010, lat);
    set_dirs(4'b0101, 4'b1010);
    screenEnd = 1'b1;
    repeat (4) tick_clk();
    reset = 1'b1; #1;
    tests++;
    if ({p1X, p1Y, p2X, p2Y, frame_done} !== {10'd32, 11'd208, 10'd544, 11'd208, 1'b0}) begin
      fails++; $display("FAIL reset_mid_pos: got (%0d,%0d)(%0d,%0d) fd=%b, want defaults",
                        p1X, p1Y, p2X, p2Y, frame_done);
    end
    pulses = 0;
    screenEnd = 1'b0;
    repeat (2) begin tick_clk(); if (frame_done) pulses++; end
    reset = 1'b0;
    repeat (10) begin tick_clk(); if (frame_done) pulses++; end
    model_reset();
    tests++;
    if (pulses != 0) begin fails++; $display("FAIL reset_mid_done: got %0d pulses, want 0", pulses); end
  endtask

  task automatic test_reset_high_release();
    int pulses, lat;
    reset = 1'b1; screenEnd = 1'b1; set_dirs(4'b0001, 4'b0000);
    repeat (2) tick_clk();
    reset = 1'b0;
    pulses = 0;
    repeat (15) begin tick_clk(); if (frame_done) pulses++; end
    model_reset();
    tests++;
    if (pulses != 0 || p1X !== 10'd32) begin
      fails++; $display("FAIL release_high: got %0d pulses x=%0d, want 0 32", pulses, p1X);
    end
    screenEnd = 1'b0;
    repeat (4) tick_clk();
    do_frame(4'b0001, 4'b0000, lat);
    tests++;
    if (lat != 5 || p1X !== 10'd35) begin
      fails++; $display("FAIL release_then_edge: got lat=%0d x=%0d, want 5 35", lat, p1X);
    end
  endtask

  task automatic test_random();
    int lat;
    logic [3:0] d1, d2;
    apply_reset();
    for (int i = 0; i < 200; i++) begin
      d1 = 4'($urandom); d2 = 4'($urandom);
      do_frame(d1, d2, lat);
      tests++;
      if ({p1X, p1Y, p2X, p2Y} !== {10'(mx1), 11'(my1), 10'(mx2), 11'(my2)} || lat != 5) begin
        fails++; $display("FAIL random_frame_%0d: got (%0d,%0d)(%0d,%0d) lat=%0d, want (%0d,%0d)(%0d,%0d) 5",
                          i, p1X, p1Y, p2X, p2Y, lat, mx1, my1, mx2, my2);
      end
    end
  endtask

  initial begin
    reset = 1'b1; screenEnd = 1'b0; set_dirs(4'b0, 4'b0);
    model_reset();
    test_reset();
    test_latency();
    test_left_edge();
    test_right_edge();
    test_opposite();
    test_collision();
    test_double_pulse();
    test_reset_mid();
    test_reset_high_release();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
